// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - exhaustive truth-table sweep controller for a 2-input gate
//
// Purpose: on start, drives the four {a,b} input vectors of a 2-input gate in
// order, holds each one for SETTLE_CYCLES cycles, samples y into obs_tt and
// finally compares obs_tt against the exp_tt captured at start.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   start   in   1  sweep request, honoured only in IDLE
//   exp_tt  in   4  expected truth table, bit i = expected y for {a,b}=i
//   y       in   1  output of the gate under test
//   a, b    out  1  gate inputs (a = MSB of vector index)
//   busy    out  1  sweep in progress
//   done    out  1  one-cycle completion pulse
//   pass    out  1  result of the last completed sweep
//   obs_tt  out  4  observed truth table
//   err_cnt out  8  saturating mismatch count (only with GATE_SWEEP_ERRCNT_EN)
//
// Optional feature macro: GATE_SWEEP_ERRCNT_EN

module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] obs_tt
`ifdef GATE_SWEEP_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // SETTLE counts down from SETTLE_CYCLES-1 to 0, giving SETTLE_CYCLES cycles.
  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] obs_q, obs_d;
  logic       pass_q, pass_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      exp_q   <= 4'd0;
      obs_q   <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    obs_d   = obs_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = exp_tt;
          obs_d   = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        obs_d[idx_q] = y;
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end else begin
          // Last sample lands in obs_d on this edge, so compare the updated table.
          pass_d  = (obs_d == exp_q);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    a    = 1'b0;
    b    = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SETTLE, SAMPLE: begin
        {a, b} = idx_q;
        busy   = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pass   = pass_q;
  assign obs_tt = obs_q;

`ifdef GATE_SWEEP_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == SAMPLE) && (y != exp_q[idx_q]) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Cleared only by reset; accumulates across sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl
//
// Purpose: table-driven and randomized sweeps against a behavioural gate
// (truth table lookup) with expected traces computed from sweep timing rules.
// Optional feature macro: GATE_SWEEP_ERRCNT_EN

module tb_gate_sweep_ctrl;

  localparam int S  = 4;
  localparam int S1 = 1;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] exp_tt;
  logic [3:0] g_tt;
  logic       y;
  logic       a, b, busy, done, pass;
  logic [3:0] obs_tt;

  logic       start1;
  logic [3:0] exp_tt1;
  logic [3:0] g1_tt;
  logic       y1;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] obs_tt1;

`ifdef GATE_SWEEP_ERRCNT_EN
  logic [7:0] err_cnt, err_cnt1;
  int         err_model;
`endif

  int n_checks;
  int n_fail;

  assign y  = g_tt[{a, b}];
  assign y1 = g1_tt[{a1, b1}];

  gate_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .exp_tt (exp_tt),
    .y      (y),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .pass   (pass),
    .obs_tt (obs_tt)
`ifdef GATE_SWEEP_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .exp_tt (exp_tt1),
    .y      (y1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .pass   (pass1),
    .obs_tt (obs_tt1)
`ifdef GATE_SWEEP_ERRCNT_EN
    ,
    .err_cnt(err_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gate;
    logic [3:0] expv;
    int         mode;
    logic [3:0] obs;
    logic       pass;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // mode 0: clean, 1: start re-pulses at cycles 3/10 and exp_tt=1111 at 7,
  // 2: random start/exp_tt noise every cycle.
  task automatic do_sweep(input logic [3:0] g, input logic [3:0] e, input int mode,
                          input logic [3:0] want_obs, input logic want_pass);
    int         lat;
    logic [1:0] v;
    lat = 4 * (S + 1) + 1;
    g_tt   = g;
    exp_tt = e;
    start  = 1'b1;
`ifdef GATE_SWEEP_ERRCNT_EN
    err_model = err_model + $countones(g ^ e);
    if (err_model > 255) err_model = 255;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin
        v = 2'((k - 1) / (S + 1));
        check("trace", 32'({a, b, busy, done}), 32'({v, 1'b1, 1'b0}));
      end else begin
        check("done_cycle", 32'({a, b, busy, done}), 32'(4'b0011));
        check("done_obs", 32'(obs_tt), 32'(want_obs));
        check("done_pass", 32'(pass), 32'(want_pass));
`ifdef GATE_SWEEP_ERRCNT_EN
        check("done_err", 32'(err_cnt), 32'(err_model));
`endif
      end
      if (mode == 1) begin
        start = (k == 3 || k == 10);
        if (k == 7) exp_tt = 4'b1111;
      end else if (mode == 2) begin
        start  = 1'($urandom_range(0, 1));
        exp_tt = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("idle_after", 32'({a, b, busy, done}), 32'(4'b0000));
    check("hold_obs", 32'(obs_tt), 32'(want_obs));
    check("hold_pass", 32'(pass), 32'(want_pass));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [3:0] rg, re;
    int         per;

    tbl[0] = '{TT_NOR,  4'b0001, 0, 4'b0001, 1'b1};
    tbl[1] = '{TT_AND,  4'b0001, 0, 4'b1000, 1'b0};
    tbl[2] = '{TT_NOR,  4'b0001, 1, 4'b0001, 1'b1};
    tbl[3] = '{TT_XOR,  4'b0110, 0, 4'b0110, 1'b1};
    tbl[4] = '{TT_NAND, 4'b1110, 0, 4'b0111, 1'b0};
    tbl[5] = '{TT_OR,   4'b1110, 2, 4'b1110, 1'b1};

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    exp_tt   = 4'd0;
    g_tt     = TT_NOR;
    start1   = 1'b0;
    exp_tt1  = 4'b0001;
    g1_tt    = TT_NOR;
`ifdef GATE_SWEEP_ERRCNT_EN
    err_model = 0;
`endif

    #3;
    check("reset_outs", 32'({a, b, busy, done, pass}), 32'(5'b0));
    check("reset_obs", 32'(obs_tt), 32'(4'b0));
    check("reset_outs1", 32'({a1, b1, busy1, done1, pass1, obs_tt1}), 32'(9'b0));
`ifdef GATE_SWEEP_ERRCNT_EN
    check("reset_err", 32'(err_cnt), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_sweep(tbl[i].gate, tbl[i].expv, tbl[i].mode, tbl[i].obs, tbl[i].pass);
    end

    for (int i = 0; i < 10; i++) begin
      rg = 4'($urandom);
      re = ($urandom_range(0, 1) == 1) ? rg : 4'($urandom);
      do_sweep(rg, re, int'($urandom_range(0, 2)), rg, (rg == re));
    end

    // Reset during the SETTLE of vector index 2.
    g_tt   = TT_NOR;
    exp_tt = 4'b0001;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * (S + 1) + 1) begin
      @(posedge clk); #1;
    end
    check("pre_reset_vec", 32'({a, b, busy}), 32'(3'b101));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 32'({a, b, busy, done, pass}), 32'(5'b0));
    check("async_rst_obs", 32'(obs_tt), 32'(4'b0));
`ifdef GATE_SWEEP_ERRCNT_EN
    err_model = 0;
    check("async_rst_err", 32'(err_cnt), 32'(0));
`endif
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'({busy, done}), 32'(2'b00));
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(TT_NOR, 4'b0001, 0, 4'b0001, 1'b1);

`ifdef GATE_SWEEP_ERRCNT_EN
    for (int i = 0; i < 64; i++) begin
      do_sweep(TT_NOR, 4'b1110, 0, 4'b0001, 1'b0);
    end
    check("err_saturated", 32'(err_cnt), 32'(255));
    do_sweep(TT_NOR, 4'b1110, 0, 4'b0001, 1'b0);
    check("err_stays_sat", 32'(err_cnt), 32'(255));
`endif

    // Back-to-back sweeps on the SETTLE_CYCLES=1 instance with start held high.
    per    = 4 * (S1 + 1) + 2;
    start1 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 30; k++) begin
      check("b2b_done", 32'(done1), 32'((k % per) == (per - 1)));
      check("b2b_busy", 32'(busy1), 32'((k % per) != 0));
      if ((k % per) == (per - 1)) begin
        check("b2b_obs", 32'(obs_tt1), 32'(TT_NOR));
        check("b2b_pass", 32'(pass1), 32'(1));
      end
      if (k == 29) start1 = 1'b0;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
